muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M-style multiply/divide unit for the execute stage. It is parametrised in WIDTH.
//  It accepts one op via valid/ready, computes in WIDTH cycles (radix-2 shift-add mul, restoring div),
//  and returns the result tagged with its destination register.
//  busy_o feeds the hazard unit as a pipeline stall; flush_i kills the op on branch/jump flush.
// PARAMETERS
//  WIDTH  32  operand/result width (even, >=4)
//  RD_W   5   destination-register tag width
// PORTS
//  clk       in   1        clock, all state updates on rising edge
//  rst       in   1        synchronous, active-high reset
//  valid_i   in   1        request valid
//  ready_o   out  1        unit can accept (state==IDLE)
//  op_i      in   3        0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  a_i       in   WIDTH    operand 1 (rs1)
//  b_i       in   WIDTH    operand 2 (rs2)
//  rd_i      in   RD_W     destination register tag
//  flush_i   in   1        abort in-flight op
//  busy_o    out  1        state!=IDLE
//  valid_o   out  1        result valid, one-cycle pulse
//  result_o  out  WIDTH    result
//  rd_o      out  RD_W     tag of result
// BEHAVIOUR
//  - Reset: state IDLE, count 0, valid_o=0, result_o=0, rd_o=0, busy_o=0, ready_o=1. Reset wins over all inputs, incl. mid-op.
//  - FSM: IDLE -> CALC -> DONE -> IDLE.
//  - Accept edge: valid_i&ready_o&!flush_i.
//    - Operands, op and tag are latched, count cleared, state->CALC.
//    - valid_i with flush_i in IDLE: request dropped.
//  - CALC: one iteration per cycle on magnitudes |a|,|b| per op signedness.
//    - MULHSU: a signed, b unsigned.
//    - After WIDTH iterations (count==WIDTH-1), sign correction is applied, result_o/rd_o load, state->DONE.
//  - Latency: accept on edge k -> valid_o high in the cycle after edge k+WIDTH.
//  - DONE: valid_o=1 for exactly one cycle, then IDLE (ready_o=1 next cycle; back-to-back accept allowed).
//    - No downstream backpressure; the consumer must sample in DONE.
//  - Multiply: full 2*WIDTH product.
//    - MUL returns the low WIDTH bits.
//    - MULH, MULHSU and MULHU return the high WIDTH bits.
//  - Divide: quotient rounds toward zero; remainder takes the sign of the dividend.
//  - Early-out special cases: CALC is skipped (accept edge -> DONE directly), valid_o in the cycle after the accept edge.
//    - Divide by zero (b==0): DIV/DIVU = all ones, REM/REMU = a.
//    - Signed overflow (DIV/REM, a=MIN_NEG, b=-1): DIV = MIN_NEG, REM = 0.
//  - flush_i in CALC: state->IDLE next edge, no valid_o for that op.
//  - flush_i in DONE: valid_o forced 0 combinationally that cycle; state->IDLE.
//  - result_o/rd_o hold their last value outside DONE; only valid_o qualifies them.
//  - No X on outputs after reset; unknown op impossible (3-bit fully decoded).
// TESTING
//  1. MUL 7 x 0xFFFFFFFD (-3), WIDTH=32.
//     -> result 0xFFFFFFEB, valid_o one cycle after edge k+32, busy_o high in between.
//  2. Multiply high variants, operands 0x80000000 x 0x80000000 unless noted:
//     -> MULH = 0x40000000.
//     -> MULHU = 0x40000000.
//     -> MULHU 0xFFFFFFFF x 0xFFFFFFFF = 0xFFFFFFFE.
//     -> MULHSU 0xFFFFFFFF x 2 = 0xFFFFFFFF.
//  3. Signed divide, -7 / 2:
//     -> DIV = 0xFFFFFFFD.
//     -> REM = 0xFFFFFFFF.
//     -> DIVU 100/7 = 14, REMU = 2.
//  4. Early-out cases:
//     -> DIVU 5/0 = 0xFFFFFFFF, REMU 5/0 = 5, valid_o in the cycle after accept.
//     -> DIV 0x80000000/0xFFFFFFFF = 0x80000000, REM = 0.
//  5. Flush and back-to-back:
//     -> flush_i in the 10th CALC cycle: no valid_o, ready_o=1 next cycle.
//     -> Next op, accepted the same cycle ready_o rises, completes normally with the correct rd_o tag.
//  6. Reset during CALC and during DONE:
//     -> next cycle valid_o=0, result_o=0, ready_o=1.
//     -> Random signed/unsigned ops checked against a reference model, 10k ops.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide on operand
// magnitudes, one iteration per cycle, with sign fix-up and divide early-outs.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [RD_W-1:0]  rd_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [RD_W-1:0]  rd_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshake: a request transfers on a rising edge where valid_i && ready_o && !flush_i;
  // valid_o is a single-cycle pulse with no backpressure and qualifies result_o/rd_o.
  typedef enum logic [1:0] {IDLE, CALC, DONE} stateE;

  stateE            state, stateNext;
  logic [2:0]       opReg;
  logic [RD_W-1:0]  rdReg;
  logic [WIDTH-1:0] bMag, hi, lo;
  logic [CW-1:0]    count;
  logic             aNeg, bNeg;

  logic             accept, aSignedIn, bSignedIn, aNegIn, bNegIn;
  logic             divZero, overflow, earlyOut;
  logic [WIDTH-1:0] aMagIn, bMagIn, earlyResult;
  logic [WIDTH:0]   mulSum, shifted, diff;
  logic [WIDTH-1:0] hiNext, loNext, quot, remv, finalRes;
  logic [2*WIDTH-1:0] prod, prodFix;

  // Request decode: signedness, magnitudes and the two divide special cases.
  always_comb begin
    accept      = valid_i && (state == IDLE) && !flush_i;
    aSignedIn   = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    bSignedIn   = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    aNegIn      = aSignedIn && a_i[WIDTH-1];
    bNegIn      = bSignedIn && b_i[WIDTH-1];
    aMagIn      = aNegIn ? -a_i : a_i;
    bMagIn      = bNegIn ? -b_i : b_i;
    divZero     = op_i[2] && (b_i == '0);
    overflow    = op_i[2] && !op_i[0] && (a_i == MIN_NEG) && (&b_i);
    earlyOut    = divZero || overflow;
    earlyResult = divZero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : MIN_NEG);
  end

  // One iteration: hi holds the running upper product / partial remainder,
  // lo holds the multiplier / dividend being shifted into the quotient.
  always_comb begin
    mulSum  = {1'b0, hi} + (lo[0] ? {1'b0, bMag} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, bMag};
    if (opReg[2]) begin
      hiNext = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      loNext = {lo[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      hiNext = mulSum[WIDTH:1];
      loNext = {mulSum[0], lo[WIDTH-1:1]};
    end
    prod    = {hiNext, loNext};
    prodFix = (aNeg ^ bNeg) ? -prod : prod;
    quot    = (aNeg ^ bNeg) ? -loNext : loNext;
    remv    = aNeg ? -hiNext : hiNext;
    case (opReg)
      3'd0:                   finalRes = prodFix[WIDTH-1:0];
      3'd1, 3'd2, 3'd3:       finalRes = prodFix[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:             finalRes = quot;
      default:                finalRes = remv;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    ready_o   = (state == IDLE);
    busy_o    = (state != IDLE);
    valid_o   = (state == DONE) && !flush_i;
    case (state)
      IDLE:    if (accept) stateNext = earlyOut ? DONE : CALC;
      CALC:    if (flush_i) stateNext = IDLE;
               else if (count == LAST) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opReg    <= '0;
      rdReg    <= '0;
      bMag     <= '0;
      hi       <= '0;
      lo       <= '0;
      count    <= '0;
      aNeg     <= 1'b0;
      bNeg     <= 1'b0;
      result_o <= '0;
      rd_o     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          opReg <= op_i;
          rdReg <= rd_i;
          aNeg  <= aNegIn;
          bNeg  <= bNegIn;
          bMag  <= bMagIn;
          hi    <= '0;
          lo    <= aMagIn;
          count <= '0;
          if (earlyOut) begin
            result_o <= earlyResult;
            rd_o     <= rd_i;
          end
        end
        CALC: begin
          hi    <= hiNext;
          lo    <= loNext;
          count <= count + 1'b1;
          // A flush on the final iteration must not disturb the held result.
          if (count == LAST && !flush_i) begin
            result_o <= finalRes;
            rd_o     <= rdReg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
